// File: rtl/frame_sync_pkg.sv
// Shared types and helpers for the frame-rate controller and game sequencer.
package frame_sync_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_GAME  = 2'b01,
        ST_END   = 2'b10,
        ST_PAUSE = 2'b11
    } game_state_t;

    function automatic int unsigned frame_period(input int unsigned clk_hz,
                                                 input int unsigned frame_hz);
        return clk_hz / frame_hz;
    endfunction

endpackage

// File: rtl/frame_req_chan.sv
// One consumer channel: level frame request cleared by ack, plus a saturating missed-frame counter.
module frame_req_chan
    import frame_sync_pkg::*;
#(
    parameter int OVR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_edge,
    input  logic             clr,
    input  logic             ack,
    output logic             request,
    output logic [OVR_W-1:0] overrun_cnt
);

    localparam logic [OVR_W-1:0] OVR_MAX = '1;

    logic             r_req;
    logic [OVR_W-1:0] r_ovr;
    logic             w_miss;

    // A frame is missed when a new edge arrives while the previous request is still unanswered.
    assign w_miss = frame_edge && r_req && !ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= 1'b0;
            r_ovr <= '0;
        end else begin
            if (frame_edge) begin
                r_req <= 1'b1;
            end else if (ack) begin
                r_req <= 1'b0;
            end
            if (clr) begin
                r_ovr <= '0;
            end else if (w_miss && (r_ovr != OVR_MAX)) begin
                r_ovr <= r_ovr + OVR_W'(1);
            end
        end
    end

    assign request     = r_req;
    assign overrun_cnt = r_ovr;

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame-rate divider, per-channel frame requests and the START/GAME/PAUSE/END game sequencer.
module frame_sync_ctrl
    import frame_sync_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned FRAME_HZ = 60,
    parameter int          N_CH     = 2,
    parameter int          OVR_W    = 8,
    parameter int          FCNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    startgame,
    input  logic                    pausegame,
    input  logic                    endgame,
    input  logic                    restart,
    input  logic [N_CH-1:0]         ack,
    output logic [1:0]              state,
    output logic [N_CH-1:0]         request,
    output logic                    frame_tick,
    output logic [FCNT_W-1:0]       frame_cnt,
    output logic [N_CH*OVR_W-1:0]   overrun_cnt
);

    localparam int unsigned PERIOD   = frame_period(CLK_HZ, FRAME_HZ);
    localparam int          DIV_W    = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD - 1);

    if (PERIOD < 2) begin : g_period_check
        $error("frame_sync_ctrl: CLK_HZ/FRAME_HZ must be at least 2");
    end

    logic [DIV_W-1:0]  r_div;
    logic              r_tick;
    logic [FCNT_W-1:0] r_fcnt;
    game_state_t       r_state;
    logic              w_frame_edge;

    assign w_frame_edge = (r_div == DIV_LAST);

    // The divider free-runs in every state; restart never disturbs the frame phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
            r_fcnt <= '0;
        end else begin
            r_div  <= w_frame_edge ? '0 : r_div + DIV_W'(1);
            r_tick <= w_frame_edge;
            if (restart) begin
                r_fcnt <= '0;
            end else if (w_frame_edge && (r_state == ST_GAME)) begin
                r_fcnt <= r_fcnt + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_START;
        end else if (restart) begin
            r_state <= ST_START;
        end else begin
            case (r_state)
                ST_START: if (startgame) r_state <= ST_GAME;
                ST_GAME: begin
                    if (endgame)        r_state <= ST_END;
                    else if (pausegame) r_state <= ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (endgame)        r_state <= ST_END;
                    else if (pausegame) r_state <= ST_GAME;
                end
                default: r_state <= r_state;
            endcase
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        frame_req_chan #(
            .OVR_W(OVR_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .frame_edge (w_frame_edge),
            .clr        (restart),
            .ack        (ack[gi]),
            .request    (request[gi]),
            .overrun_cnt(overrun_cnt[gi*OVR_W +: OVR_W])
        );
    end

    assign state      = r_state;
    assign frame_tick = r_tick;
    assign frame_cnt  = r_fcnt;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed plus randomized bench for frame_sync_ctrl with a cycle-level behavioural reference model.
module tb_frame_sync_ctrl;

    localparam int P      = 10;
    localparam int NCH    = 3;
    localparam int OVRW   = 2;
    localparam int OVRMAX = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 startgame, pausegame, endgame, restart;
    logic [NCH-1:0]       ack;
    logic [1:0]           state;
    logic [NCH-1:0]       request;
    logic                 frame_tick;
    logic [15:0]          frame_cnt;
    logic [NCH*OVRW-1:0]  overrun_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: game state as 0=START 1=GAME 2=END 3=PAUSE
    int          edge_n;
    int          m_st;
    logic [2:0]  m_req;
    int          m_ovr [NCH];
    int          m_fcnt;
    logic        m_tick;

    frame_sync_ctrl #(
        .CLK_HZ  (1000),
        .FRAME_HZ(100),
        .N_CH    (NCH),
        .OVR_W   (OVRW),
        .FCNT_W  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .startgame  (startgame),
        .pausegame  (pausegame),
        .endgame    (endgame),
        .restart    (restart),
        .ack        (ack),
        .state      (state),
        .request    (request),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_ovr();
        return 32'((m_ovr[2] << 4) | (m_ovr[1] << 2) | m_ovr[0]);
    endfunction

    task automatic model_reset();
        edge_n = 0;
        m_st   = 0;
        m_req  = '0;
        m_fcnt = 0;
        m_tick = 1'b0;
        for (int i = 0; i < NCH; i++) m_ovr[i] = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(m_st));
        chk({tag, "_req"}, 32'(request), 32'(m_req));
        chk({tag, "_tick"}, 32'(frame_tick), 32'(m_tick));
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'(m_fcnt));
        chk({tag, "_ovr"}, 32'(overrun_cnt), exp_ovr());
    endtask

    // Phase of the upcoming clock edge within the frame; phase 0 is a frame edge.
    function automatic int ph();
        return (edge_n + 1) % P;
    endfunction

    task automatic cyc(input string tag, input logic sg, input logic pg, input logic eg,
                       input logic rs, input logic [2:0] a);
        bit fe;
        int nst;
        startgame = sg; pausegame = pg; endgame = eg; restart = rs; ack = a;
        @(posedge clk);
        #1;
        edge_n++;
        fe  = ((edge_n % P) == 0);
        nst = m_st;
        if (rs) nst = 0;
        else begin
            case (m_st)
                0: if (sg) nst = 1;
                1: if (eg) nst = 2; else if (pg) nst = 3;
                3: if (eg) nst = 2; else if (pg) nst = 1;
                default: ;
            endcase
        end
        for (int i = 0; i < NCH; i++) begin
            if (rs) m_ovr[i] = 0;
            else if (fe && m_req[i] && !a[i] && m_ovr[i] < OVRMAX) m_ovr[i]++;
            if (fe) m_req[i] = 1'b1;
            else if (a[i]) m_req[i] = 1'b0;
        end
        if (rs) m_fcnt = 0;
        else if (fe && m_st == 1) m_fcnt = (m_fcnt + 1) & 16'hFFFF;
        m_st   = nst;
        m_tick = fe;
        startgame = 0; pausegame = 0; endgame = 0; restart = 0; ack = '0;
        chk_all(tag);
    endtask

    task automatic idle_to_phase(input string tag, input int target);
        for (int k = 0; k < P && ph() != target; k++) cyc(tag, 0, 0, 0, 0, 3'b000);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_req"}, 32'(request), 32'd0);
        chk({tag, "_tick"}, 32'(frame_tick), 32'd0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun_cnt), 32'd0);
    endtask

    initial begin
        int saved;
        rst = 1'b1;
        startgame = 0; pausegame = 0; endgame = 0; restart = 0; ack = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        // Idle after reset: first tick on the 10th edge, then every 10
        for (int k = 1; k <= 25; k++) begin
            cyc("idle", 0, 0, 0, 0, 3'b000);
            if (k == 9)  chk("pre_first_tick", 32'(frame_tick), 32'd0);
            if (k == 10) chk("first_tick", 32'(frame_tick), 32'd1);
            if (k == 10) chk("first_req", 32'(request), 32'h7);
            if (k == 20) chk("second_tick", 32'(frame_tick), 32'd1);
        end
        chk("start_fcnt0", 32'(frame_cnt), 32'd0);

        // Restart, start game, ack all two cycles after every tick for 5 frames
        idle_to_phase("align", 1);
        cyc("restart1", 0, 0, 0, 1, 3'b000);
        cyc("start", 1, 0, 0, 0, 3'b111);
        for (int k = 0; k < 5 * P; k++)
            cyc("ackall", 0, 0, 0, 0, (ph() == 2) ? 3'b111 : 3'b000);
        chk("game_state", 32'(state), 32'd1);
        chk("game_fcnt5", 32'(frame_cnt), 32'd5);
        chk("game_ovr0", 32'(overrun_cnt), 32'd0);

        // Channel 1 never acks: its overrun counter saturates
        for (int k = 0; k < 6 * P; k++)
            cyc("ch1miss", 0, 0, 0, 0, (ph() == 2) ? 3'b101 : 3'b000);
        chk("ch1_sat", 32'(overrun_cnt[3:2]), 32'd3);
        chk("ch0_zero", 32'(overrun_cnt[1:0]), 32'd0);
        chk("ch2_zero", 32'(overrun_cnt[5:4]), 32'd0);

        // Pause for three frames, then resume
        idle_to_phase("align", 1);
        cyc("pause", 0, 1, 0, 0, 3'b000);
        chk("paused_state", 32'(state), 32'd3);
        saved = m_fcnt;
        for (int k = 0; k < 3 * P; k++)
            cyc("paused", 0, 0, 0, 0, (ph() == 2) ? 3'b111 : 3'b000);
        chk("pause_frozen", 32'(frame_cnt), 32'(saved));
        cyc("resume", 0, 1, 0, 0, 3'b000);
        chk("resumed_state", 32'(state), 32'd1);

        // Ack in the exact frame-edge cycle, then restart on a frame edge
        for (int k = 0; k < 3 * P; k++)
            cyc("edgeack", 0, 0, 0, 0, (ph() == 0) ? 3'b111 : 3'b000);
        idle_to_phase("align", 0);
        cyc("restart_edge", 0, 0, 0, 1, 3'b000);
        chk("rse_state", 32'(state), 32'd0);
        chk("rse_fcnt", 32'(frame_cnt), 32'd0);
        chk("rse_ovr", 32'(overrun_cnt), 32'd0);
        chk("rse_req", 32'(request), 32'h7);
        chk("rse_tick", 32'(frame_tick), 32'd1);

        // endgame and pausegame together go to END; startgame is then ignored
        cyc("start2", 1, 0, 0, 0, 3'b000);
        cyc("end_pause", 0, 1, 1, 0, 3'b000);
        chk("end_state", 32'(state), 32'd2);
        cyc("start_in_end", 1, 0, 0, 0, 3'b000);
        chk("end_hold", 32'(state), 32'd2);

        // Random traffic
        for (int k = 0; k < 400; k++)
            cyc("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 29) == 0), ($urandom_range(0, 49) == 0),
                3'($urandom_range(0, 7) & $urandom_range(0, 7)));

        // Asynchronous reset mid-frame
        idle_to_phase("align", 5);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_vals("rst_hold");
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc("post_rst", 0, 0, 0, 0, 3'b000);
            if (k == 10) chk("post_rst_tick", 32'(frame_tick), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_sync_ctrl.md
# frame_sync_ctrl

Parametrised frame-rate controller and game-mode sequencer for the VGA/game-control merge. Divides the system clock into a configurable frame rate and issues a per-frame request to each of N_CH consumers (renderer, game logic, sound, ...), each with its own acknowledge. It tracks missed frames per channel and runs a four-state game FSM that adds pause and restart.

## Interface
- CLK_HZ, default 50_000_000: system clock frequency in Hz.
- FRAME_HZ, default 60: frame rate in Hz. PERIOD = CLK_HZ/FRAME_HZ (integer division, 833333 at defaults). PERIOD >= 2, enforced by elaboration assertion.
- N_CH, default 2: number of request/ack channels, >= 1.
- OVR_W, default 8: width of each per-channel overrun counter.
- FCNT_W, default 16: width of the frame counter.
- clk  in  1: system clock.
- rst  in  1: asynchronous, active-high reset.
- startgame  in  1: START -> GAME.
- pausegame  in  1: toggles GAME <-> PAUSE.
- endgame  in  1: GAME/PAUSE -> END.
- restart  in  1: any state -> START.
- ack  in  N_CH: per-channel acknowledge.
- state  out  2: game state (START=00, GAME=01, END=10, PAUSE=11).
- request  out  N_CH: per-channel frame request, level.
- frame_tick  out  1: one-cycle pulse per frame.
- frame_cnt  out  FCNT_W: frames elapsed while in GAME.
- overrun_cnt  out  N_CH*OVR_W: per-channel missed-frame counts. Channel i occupies bits [i*OVR_W +: OVR_W].

## Operation
- Divider: counter of width $clog2(PERIOD) runs 0..PERIOD-1 and wraps to 0. The wrap edge is the frame edge. The divider runs in every state and is never cleared by restart.
- Frame edge sets frame_tick=1 for one cycle and sets request[i]=1 for every channel.
- Request, per channel, with next-state priority top-down:
  - frame edge -> 1.
  - ack[i] -> 0.
  - else hold.
  - ack on a channel whose request is 0 is ignored.
- Overrun: at a frame edge with request[i]==1 and ack[i]==0, overrun_cnt[i] increments.
  - Saturates at 2^OVR_W-1.
  - Cleared only by rst or restart.
  - Frame edge with ack[i]==1 in the same cycle: request stays 1, no overrun.
- FSM, next state, priority top-down:
  - restart: -> START from any state.
  - START: startgame -> GAME.
  - GAME: endgame -> END; else pausegame -> PAUSE.
  - PAUSE: endgame -> END; else pausegame -> GAME.
  - END: hold.
- Inputs are treated as single-cycle pulses. A level held high on pausegame toggles every cycle; the caller must pulse it.
- frame_cnt increments (wrapping) at a frame edge only while state==GAME. It holds in PAUSE/END and is cleared by restart.
- Requests are issued in all states; the display keeps redrawing title, pause and end screens.

## Timing
- Reset values: state=START, request=0, frame_tick=0, frame_cnt=0, overrun_cnt=0, divider=0.
- All outputs are registered. No combinational input-to-output path.
- After rst deasserts, the first frame_tick/request are high in the cycle following the PERIOD-th rising edge. Subsequent frame edges follow every PERIOD cycles exactly.
- ack[i] sampled at edge n: request[i] is low after edge n.
- FSM input at edge n: state is updated after edge n.
- frame_cnt and overrun_cnt update at the same edge as frame_tick rises. A frame edge coinciding with the GAME entry edge does not count (the old state is used).
- restart coinciding with a frame edge: request still rises, frame_tick still pulses. frame_cnt and overrun_cnt go to 0 (clear wins over increment).
- rst mid-frame: everything returns to reset values immediately. Divider phase restarts.

## Structure
- Package frame_sync_pkg holds:
  - game_state_t enum with the encodings above (existing encodings are preserved).
  - function frame_period(CLK_HZ, FRAME_HZ).
- Sub-module frame_req_chan: one channel's request flop plus its saturating overrun counter. Inputs: clk, rst, frame_edge, clr, ack. Instantiated N_CH times in a generate loop.
- The top level holds the divider, FSM and frame_cnt.

## Test plan
All scenarios use CLK_HZ=1000, FRAME_HZ=100 (PERIOD=10), N_CH=3, OVR_W=2.
- Reset release, no inputs -> frame_tick high in cycle 10, then every 10 cycles. request=3'b111 from cycle 10 onward. frame_cnt stays 0 in START.
- startgame pulse, then ack all channels 2 cycles after each tick for 5 frames -> state=GAME, frame_cnt=5, request drops 1 cycle after each ack, overrun_cnt all 0.
- Channel 1 never acks for 6 frames -> overrun_cnt[1] counts 1, 2, 3 and saturates at 3. Other channels stay at 0.
- In GAME, pausegame, wait 3 frames, pausegame -> state 01->11->01. frame_cnt frozen for those 3 frames. Requests keep pulsing.
- ack asserted in the exact frame-edge cycle -> request stays 1, no overrun increment. Then restart on a frame edge -> state=START, frame_cnt=0, overrun_cnt=0, request=111.
- endgame and pausegame in the same cycle in GAME -> END. Later startgame is ignored. rst asserted mid-frame -> all outputs return to reset values without waiting for a clock edge.
